// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-drive signals of alu_sequencer, bundled into one interface.
// slave is the sequencer's view and master is the view of whatever sits around it.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_cmp;
    logic        rsp_zero;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cont;
    logic [31:0] alu_res;
    logic [31:0] alu_cmp;
    logic        alu_zero;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_res, alu_cmp, alu_zero,
        output req_ready, rsp_valid, rsp_data, rsp_cmp, rsp_zero, rsp_err, alu_a, alu_b, alu_cont
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_res, alu_cmp, alu_zero,
        input  req_ready, rsp_valid, rsp_data, rsp_cmp, rsp_zero, rsp_err, alu_a, alu_b, alu_cont
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer in front of the combinational alu32; MUL (shift-add over 32 ALU adds) exists only with ALU_SEQ_MUL_EN.
// Latency is 2 cycles for single-pass ops, 33 for MUL and 1 for illegal ops; a response holds while rsp_ready is low.
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
`endif

    localparam logic [2:0] CONT_AND = 3'b000;
    localparam logic [2:0] CONT_OR  = 3'b001;
    localparam logic [2:0] CONT_ADD = 3'b010;
    localparam logic [2:0] CONT_SUB = 3'b110;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, RESP, MUL_STEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cont;
    logic        req_single;
    logic        req_illegal;
    logic [31:0] exec_data;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_cmp;
    logic        rsp_zero;
    logic        rsp_err;
    logic        alu_cmp_unused;

`ifdef ALU_SEQ_MUL_EN
    logic        req_mul;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  step;
`endif

    function automatic logic [2:0] cont_of(input logic [2:0] op);
        case (op)
            OP_ADD:  return CONT_ADD;
            OP_AND:  return CONT_AND;
            OP_OR:   return CONT_OR;
            default: return CONT_SUB;
        endcase
    endfunction

    always_comb begin
        req_single  = 1'b0;
        req_illegal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        req_mul     = 1'b0;
`endif
        case (bus.req_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_CMP: begin
                req_single  = 1'b1;
                req_illegal = 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                req_mul     = 1'b1;
                req_illegal = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_cont  = CONT_ADD;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_single)
                        state_nxt = EXEC;
`ifdef ALU_SEQ_MUL_EN
                    else if (req_mul)
                        state_nxt = MUL_STEP;
`endif
                    else
                        state_nxt = RESP;
                end
            end
            EXEC: begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_cont  = cont_of(op_q);
                state_nxt = RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_STEP: begin
                alu_a = acc;
                alu_b = mplier[0] ? mcand : '0;
                if (step == 5'd31)
                    state_nxt = RESP;
            end
`endif
            RESP: begin
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SLT/CMP read the ALU sign code as-is; wrapped differences keep the wrapped sign.
    always_comb begin
        case (op_q)
            OP_SLT:  exec_data = {31'b0, bus.alu_cmp[1:0] == 2'b10};
            OP_CMP:  exec_data = {30'b0, bus.alu_cmp[1:0]};
            default: exec_data = bus.alu_res;
        endcase
    end

    assign alu_cmp_unused = ^bus.alu_cmp[31:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_cmp  <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            step     <= '0;
`endif
        end else begin
            if (state == IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
`ifdef ALU_SEQ_MUL_EN
                acc    <= '0;
                mcand  <= bus.req_a;
                mplier <= bus.req_b;
                step   <= '0;
`endif
                if (req_illegal) begin
                    rsp_data <= '0;
                    rsp_cmp  <= '0;
                    rsp_zero <= 1'b0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == EXEC) begin
                rsp_data <= exec_data;
                rsp_cmp  <= bus.alu_cmp[1:0];
                rsp_zero <= bus.alu_zero;
                rsp_err  <= 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            if (state == MUL_STEP) begin
                acc    <= bus.alu_res;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + 5'd1;
                if (step == 5'd31) begin
                    rsp_data <= bus.alu_res;
                    rsp_cmp  <= bus.alu_cmp[1:0];
                    rsp_zero <= bus.alu_zero;
                    rsp_err  <= 1'b0;
                end
            end
`endif
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_cmp   = rsp_cmp;
    assign bus.rsp_zero  = rsp_zero;
    assign bus.rsp_err   = rsp_err;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_cont  = alu_cont;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural alu32 and a response scoreboard.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [1:0] cmp_code(input logic [31:0] r);
        if (r == 32'd0)  return 2'b01;
        else if (r[31])  return 2'b10;
        else             return 2'b11;
    endfunction

    logic [31:0] alu_r;
    always_comb begin
        case (bus.alu_cont)
            3'b000:  alu_r = bus.alu_a & bus.alu_b;
            3'b001:  alu_r = bus.alu_a | bus.alu_b;
            3'b010:  alu_r = bus.alu_a + bus.alu_b;
            3'b110:  alu_r = bus.alu_a - bus.alu_b;
            default: alu_r = 32'd0;
        endcase
        bus.alu_res  = alu_r;
        bus.alu_zero = (alu_r == 32'd0);
        bus.alu_cmp  = {30'd0, cmp_code(alu_r)};
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  cmp;
        logic        zero;
        logic        err;
    } rsp_t;

    rsp_t sb[$];

    function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t        e;
        logic [31:0] d;
        logic        legal;
        d     = a - b;
        legal = 1'b1;
        case (op)
            3'd0: e.data = a + b;
            3'd1: e.data = d;
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = (cmp_code(d) == 2'b10) ? 32'd1 : 32'd0;
            3'd5: e.data = {30'd0, cmp_code(d)};
`ifdef ALU_SEQ_MUL_EN
            3'd6: e.data = a * b;
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.data = 32'd0;
            e.cmp  = 2'b00;
            e.zero = 1'b0;
            e.err  = 1'b1;
        end else if (op == 3'd4 || op == 3'd5) begin
            e.cmp  = cmp_code(d);
            e.zero = (d == 32'd0);
            e.err  = 1'b0;
        end else begin
            e.cmp  = cmp_code(e.data);
            e.zero = (e.data == 32'd0);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        if (op <= 3'd5) return 2;
`ifdef ALU_SEQ_MUL_EN
        if (op == 3'd6) return 33;
`endif
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!bus.rsp_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, bus.rsp_data, e.data);
            chk({tag, "_cmp"},  bus.rsp_cmp,  e.cmp);
            chk({tag, "_zero"}, bus.rsp_zero, e.zero);
            chk({tag, "_err"},  bus.rsp_err,  e.err);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data,  0);
        chk({tag, "_rsp_cmp"},   bus.rsp_cmp,   0);
        chk({tag, "_rsp_zero"},  bus.rsp_zero,  0);
        chk({tag, "_rsp_err"},   bus.rsp_err,   0);
        chk({tag, "_alu_a"},     bus.alu_a,     0);
        chk({tag, "_alu_b"},     bus.alu_b,     0);
        chk({tag, "_alu_cont"},  bus.alu_cont,  32'h2);
    endtask

    // Called #1 after a clock edge with the sequencer idle and rsp_ready high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, "_busy"}, bus.req_ready, 0);
        wait_rsp(n);
        chk({tag, "_latency"}, n, lat_of(op));
        check_rsp(tag);
        @(posedge clk); #1;
        chk({tag, "_ready_back"}, bus.req_ready, 1);
        chk({tag, "_valid_drop"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add",      3'd0, 32'h0000_0005, 32'h0000_0003);
        run_op("sub_eq",   3'd1, 32'h1234_5678, 32'h1234_5678);
        run_op("cmp_lt",   3'd5, 32'd3, 32'd9);
        run_op("slt_lt",   3'd4, 32'd3, 32'd9);
        run_op("slt_wrap", 3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op("or",       3'd3, 32'h0000_00F0, 32'h0000_0F0F);
        run_op("cmp_gt",   3'd5, 32'd9, 32'd3);
        run_op("mul_a",    3'd6, 32'h0001_0003, 32'h0000_0007);
        run_op("mul_b",    3'd6, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("illegal",  3'd7, 32'hDEAD_BEEF, 32'h1);

        // Response held off; a second request waits on req_valid the whole time.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd2;
        bus.req_a     = 32'h0000_F0F0;
        bus.req_b     = 32'h0000_FF00;
        sb.push_back(model(3'd2, 32'h0000_F0F0, 32'h0000_FF00));
        @(posedge clk); #1;
        bus.req_op = 3'd3;
        bus.req_a  = 32'h1;
        bus.req_b  = 32'h2;
        wait_rsp(n);
        chk("bp_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data",      bus.rsp_data,  32'hF000);
            chk("bp_valid",     bus.rsp_valid, 1);
            chk("bp_req_ready", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        check_rsp("bp_and");
        sb.push_back(model(3'd3, 32'h1, 32'h2));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_ready", bus.req_ready, 1);
        chk("bp_hs_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_second_taken", bus.req_ready, 0);
        wait_rsp(n);
        chk("bp_second_latency", n, 2);
        check_rsp("bp_or");
        @(posedge clk); #1;

        // Mid-operation reset: MUL step 10 when multiply is built, otherwise a held illegal response.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd6;
        bus.req_a     = 32'h0000_1234;
        bus.req_b     = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", bus.req_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", bus.rsp_valid, 0);

        run_op("illegal_after_rst", 3'd7, 32'h5, 32'h6);
        run_op("op110_after_rst",   3'd6, 32'h3, 32'h4);
        run_op("and_after_rst",     3'd2, 32'hFFFF_0000, 32'h00FF_FF00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
